// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority request arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Callers zero-extend to 32 bits and truncate the result to their index width.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: reports the highest set index of req, binary and one-hot.
module prio_pick #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    output logic            found,
    output logic [IDXW-1:0] idx,
    output logic [N-1:0]    onehot
);

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                found     = 1'b1;
                idx       = IDXW'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arbiter_rr.sv
// Registered N-way arbiter with fixed-priority and round-robin modes, grant hold and hold-limit timeout.
// The owner's done strobe is called release_grant because "release" is a reserved word.
module prio_arbiter_rr
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int IDXW     = $clog2(N),
    parameter int HOLD_MAX = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [N-1:0]    req,
    input  logic            release_grant,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam int HCW = $clog2(HOLD_MAX + 1);

    arb_state_t      state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
    logic            timeout_q, timeout_d;

    logic [N-1:0]    elig, elig_rev, masked_rev;
    logic            fx_found, rm_found, ru_found;
    logic [IDXW-1:0] fx_idx, rm_idx, ru_idx, rr_rev_idx;
    logic [N-1:0]    fx_oh, rm_oh, ru_oh, rr_rev_oh;
    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic [N-1:0]    win_oh;

    // The current owner is never eligible; outside OWN gnt_q is zero so nothing is excluded.
    // Round-robin wants the lowest index at or above rr_ptr, so its pickers see reversed vectors.
    always_comb begin
        elig       = req & ~gnt_q;
        elig_rev   = '0;
        masked_rev = '0;
        for (int i = 0; i < N; i++) begin
            elig_rev[i]   = elig[N-1-i];
            masked_rev[i] = elig[N-1-i] & ((N - 1 - i) >= int'(rr_ptr_q));
        end
    end

    prio_pick #(.N(N), .IDXW(IDXW)) u_pick_fixed (
        .req(elig), .found(fx_found), .idx(fx_idx), .onehot(fx_oh)
    );

    prio_pick #(.N(N), .IDXW(IDXW)) u_pick_masked (
        .req(masked_rev), .found(rm_found), .idx(rm_idx), .onehot(rm_oh)
    );

    prio_pick #(.N(N), .IDXW(IDXW)) u_pick_unmasked (
        .req(elig_rev), .found(ru_found), .idx(ru_idx), .onehot(ru_oh)
    );

    assign rr_rev_idx = rm_found ? rm_idx : ru_idx;
    assign rr_rev_oh  = rm_found ? rm_oh : ru_oh;

    always_comb begin
        win_found = fx_found;
        win_idx   = fx_idx;
        win_oh    = fx_oh;
        if (mode == MODE_RR) begin
            win_found = rm_found | ru_found;
            win_idx   = IDXW'(N - 1) - rr_rev_idx;
            for (int i = 0; i < N; i++) begin
                win_oh[i] = rr_rev_oh[N-1-i];
            end
        end
    end

    always_comb begin
        logic owner_req;
        logic at_limit;
        logic new_grant;

        state_d    = state_q;
        gnt_d      = gnt_q;
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        timeout_d  = 1'b0;
        new_grant  = 1'b0;
        owner_req  = |(req & gnt_q);
        at_limit   = (hold_cnt_q == HCW'(HOLD_MAX));

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    new_grant = 1'b1;
                end
            end
            OWN: begin
                if (release_grant || !owner_req || at_limit) begin
                    // Only a grant the owner still wanted counts as revoked by the limit.
                    timeout_d = at_limit && !release_grant && owner_req;
                    if (win_found) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        gnt_d      = '0;
                        hold_cnt_d = '0;
                    end
                end else if (!at_limit) begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        if (new_grant) begin
            state_d    = OWN;
            gnt_d      = win_oh;
            hold_cnt_d = HCW'(1);
            if (mode == MODE_RR) begin
                rr_ptr_d = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + IDXW'(1);
            end
        end

        gnt_idx_d = IDXW'(onehot_to_idx(32'(gnt_d)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Directed bench for prio_arbiter_rr: a 4-way instance with HOLD_MAX=16 and a 5-way instance for wrap checks.
module tb_prio_arbiter_rr;
    import arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       mode, release_grant;
    logic [3:0] req, gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid, timeout;

    logic       mode5, release5;
    logic [4:0] req5, gnt5;
    logic [2:0] gnt_idx5;
    logic       gnt_valid5, timeout5;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [3:0]  vecs[7];

    always #5 clk = ~clk;

    prio_arbiter_rr #(.N(4), .HOLD_MAX(16)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .req(req), .release_grant(release_grant),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    prio_arbiter_rr #(.N(5), .HOLD_MAX(16)) u_dut5 (
        .clk(clk), .rst(rst), .mode(mode5), .req(req5), .release_grant(release5),
        .gnt(gnt5), .gnt_idx(gnt_idx5), .gnt_valid(gnt_valid5), .timeout(timeout5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input int idx);
        check({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
        check({tag, "_gnt"}, 32'(gnt), 32'(1) << idx);
        check({tag, "_valid"}, 32'(gnt_valid), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_idx"}, 32'(gnt_idx), 32'd0);
        check({tag, "_valid"}, 32'(gnt_valid), 32'd0);
    endtask

    task automatic check_grant5(input string tag, input int idx);
        check({tag, "_idx"}, 32'(gnt_idx5), 32'(idx));
        check({tag, "_gnt"}, 32'(gnt5), 32'(1) << idx);
    endtask

    initial begin
        mode          = MODE_RR;
        release_grant = 1'b0;
        req           = 4'b0010;
        mode5         = MODE_RR;
        release5      = 1'b0;
        req5          = 5'b00000;
        #12 rst = 1'b0;

        // Reset: move rr_ptr, take a grant, then reset mid-grant without a clock edge.
        step();
        check_grant("rr_first", 1);
        mode = MODE_FIXED;
        req  = 4'b1000;
        step();
        check_grant("pre_reset", 3);
        #3 rst = 1'b1;
        #1;
        check_idle("async_reset");
        check("async_reset_to", 32'(timeout), 32'd0);
        step();
        rst  = 1'b0;
        mode = MODE_RR;
        req  = 4'b1111;
        step();
        check_grant("rr_ptr_reset", 0);

        // Round-robin rotation with release every cycle.
        release_grant = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_grant("rr_rotate", k % 4);
        end

        // Fixed priority, original encoder vectors with an idle cycle between them.
        req  = 4'b0000;
        mode = MODE_FIXED;
        step();
        check_idle("fixed_idle0");
        vecs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0110, 4'b1100, 4'b1111};
        exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd2, 32'd3, 32'd3};
        for (int i = 0; i < 7; i++) begin
            req = vecs[i];
            step();
            check_grant("fixed_vec", int'(exp_q.pop_front()));
            req = 4'b0000;
            step();
            check_idle("fixed_zero");
        end

        // Owner drops its request: grant moves to the next eligible requester.
        release_grant = 1'b0;
        req           = 4'b1010;
        step();
        check_grant("drop_own3", 3);
        req = 4'b0010;
        step();
        check_grant("drop_move1", 1);
        release_grant = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            if (j % 2 == 0) check_idle("regrant_gap");
            else            check_grant("regrant", 1);
        end

        // Hold limit: owner 1 keeps the grant 16 cycles, then timeout hands it to 0.
        release_grant = 1'b0;
        req           = 4'b0000;
        step();
        check_idle("to_idle");
        req = 4'b0011;
        step();
        check_grant("to_start", 1);
        check("to_start_pulse", 32'(timeout), 32'd0);
        for (int c = 2; c <= 16; c++) begin
            step();
            check("to_hold_idx", 32'(gnt_idx), 32'd1);
            check("to_hold_pulse", 32'(timeout), 32'd0);
        end
        step();
        check("to_fire_pulse", 32'(timeout), 32'd1);
        check_grant("to_fire", 0);
        step();
        check("to_after_pulse", 32'(timeout), 32'd0);
        check_grant("to_after", 0);

        // Mode switch mid-grant on the 5-way instance, then round-robin wrap 4 -> 0.
        req5 = 5'b00100;
        step();
        check_grant5("m5_rr_prime", 2);
        req5 = 5'b00000;
        step();
        check("m5_idle", 32'(gnt_valid5), 32'd0);
        mode5 = MODE_FIXED;
        req5  = 5'b00100;
        step();
        check_grant5("m5_fixed", 2);
        mode5 = MODE_RR;
        req5  = 5'b11111;
        step();
        check_grant5("m5_hold_a", 2);
        step();
        check_grant5("m5_hold_b", 2);
        release5 = 1'b1;
        step();
        check_grant5("m5_rr_next", 3);
        step();
        check_grant5("m5_rr_top", 4);
        step();
        check_grant5("m5_rr_wrap", 0);
        check("m5_no_timeout", 32'(timeout5), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
